// File: rtl/cdu_pkg.sv
// Shared types and constants for the CDU increment scheduler.
// Five angle channels share one AGC counter-increment line.
package cdu_pkg;

  localparam int NCH = 5;
  localparam int CW  = 4;

  localparam int CH_X = 0;
  localparam int CH_Y = 1;
  localparam int CH_Z = 2;
  localparam int CH_T = 3;
  localparam int CH_S = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_DRIVE,
    ST_RECOV
  } cdu_state_e;

endpackage

// File: rtl/cdu_incr_scheduler_if.sv
// Strobe, increment and AGC-line bundle of the scheduler.
// master drives timing and increments, slave is the scheduler.
interface cdu_incr_scheduler_if;
  import cdu_pkg::*;

  logic           FAZ1HI;
  logic           FAZ2HI;
  logic           FAZ3HI;
  logic           FAZ4HI;
  logic           ENABLE;
  logic [NCH-1:0] INC_P;
  logic [NCH-1:0] INC_M;
  logic           OVFCLR;
  logic           PULSE_P;
  logic           PULSE_M;
  logic [2:0]     CHSEL;
  logic           BUSY;
  logic [NCH-1:0] PEND;
  logic [NCH-1:0] OVF;

  modport master (
    output FAZ1HI, FAZ2HI, FAZ3HI, FAZ4HI,
    output ENABLE, INC_P, INC_M, OVFCLR,
    input  PULSE_P, PULSE_M, CHSEL,
    input  BUSY, PEND, OVF
  );

  modport slave (
    input  FAZ1HI, FAZ2HI, FAZ3HI, FAZ4HI,
    input  ENABLE, INC_P, INC_M, OVFCLR,
    output PULSE_P, PULSE_M, CHSEL,
    output BUSY, PEND, OVF
  );

endinterface

// File: rtl/cdu_chan_accum.sv
// Per-channel saturating signed pending-pulse counter.
// Excess beyond either bound is dropped and flagged sticky.
module cdu_chan_accum
  import cdu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc_p,
  input  logic inc_m,
  input  logic step_en,
  input  logic step_neg,
  input  logic ovf_clr,
  output logic neg,
  output logic pend,
  output logic ovf
);

  localparam int MAXI = 2**(CW-1) - 1;
  localparam int MINI = -(2**(CW-1));
  localparam logic signed [CW+1:0] MAXV = (CW+2)'(MAXI);
  localparam logic signed [CW+1:0] MINV = (CW+2)'(MINI);
  localparam logic signed [CW+1:0] ONE  = (CW+2)'(1);

  logic        [CW-1:0] cnt;
  logic        [CW-1:0] nxt;
  logic signed [CW+1:0] delta;
  logic signed [CW+1:0] sum;
  logic                 hit;

  // Net change this cycle, then clamp to the signed range.
  always_comb begin
    delta = '0;
    if (inc_p) delta = delta + ONE;
    if (inc_m) delta = delta - ONE;
    if (step_en) begin
      if (step_neg) delta = delta + ONE;
      else          delta = delta - ONE;
    end
    sum = {{2{cnt[CW-1]}}, cnt} + delta;
    nxt = sum[CW-1:0];
    hit = 1'b0;
    if (sum > MAXV) begin
      nxt = MAXV[CW-1:0];
      hit = 1'b1;
    end else if (sum < MINV) begin
      nxt = MINV[CW-1:0];
      hit = 1'b1;
    end
  end

  // Count, nonzero flag and sticky overflow (new overflow beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      pend <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      cnt  <= nxt;
      pend <= (nxt != '0);
      ovf  <= hit | (ovf & ~ovf_clr);
    end
  end

  assign neg = cnt[CW-1];

endmodule

// File: rtl/cdu_incr_scheduler.sv
// Round-robin drain of per-channel increments onto the AGC line.
// One pulse per FAZ1..FAZ4 frame; sign is fixed at arbitration.
module cdu_incr_scheduler
  import cdu_pkg::*;
(
  input  logic _51KPHI,
  input  logic rst_n,
  cdu_incr_scheduler_if.slave bus
);

  logic           clk;
  cdu_state_e     state;
  cdu_state_e     state_nxt;
  logic [2:0]     ptr;
  logic [2:0]     chsel;
  logic [2:0]     pick;
  logic [2:0]     idx;
  logic           found;
  logic           sign_neg;
  logic           pulse_p;
  logic           pulse_m;
  logic           driving;
  logic           phase3;
  logic           fire;
  logic           serve;
  logic           busy;
  logic [NCH-1:0] step_en;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] ovf;
  logic [NCH-1:0] cnt_neg;

  assign clk     = _51KPHI;
  assign driving = pulse_p | pulse_m;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    cdu_chan_accum u_acc (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc_p    (bus.INC_P[i]),
      .inc_m    (bus.INC_M[i]),
      .step_en  (step_en[i]),
      .step_neg (sign_neg),
      .ovf_clr  (bus.OVFCLR),
      .neg      (cnt_neg[i]),
      .pend     (pend[i]),
      .ovf      (ovf[i])
    );
  end

  // First pending channel after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = 3'((int'(ptr) + k) % NCH);
      if (!found && pend[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state; strobes outside their expected state are ignored.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (bus.FAZ1HI && bus.ENABLE && (|pend))
          state_nxt = ST_ARB;
      ST_ARB:
        state_nxt = found ? ST_DRIVE : ST_RECOV;
      ST_DRIVE:
        if (serve) state_nxt = ST_RECOV;
      ST_RECOV:
        state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // Frame events and the one-hot served step.
  always_comb begin
    busy  = (state != ST_IDLE);
    fire  = (state == ST_DRIVE) && bus.FAZ2HI && !driving;
    serve = (state == ST_DRIVE) && bus.FAZ4HI && phase3;
    for (int i = 0; i < NCH; i++)
      step_en[i] = serve && (chsel == 3'(i));
  end

  // Arbitration latch and registered pulse drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 3'(NCH-1);
      chsel    <= '0;
      sign_neg <= 1'b0;
      pulse_p  <= 1'b0;
      pulse_m  <= 1'b0;
      phase3   <= 1'b0;
    end else begin
      if (state == ST_ARB && found) begin
        chsel    <= pick;
        ptr      <= pick;
        sign_neg <= cnt_neg[pick];
      end
      if (fire) begin
        pulse_p <= !sign_neg;
        pulse_m <= sign_neg;
      end else if (serve) begin
        pulse_p <= 1'b0;
        pulse_m <= 1'b0;
      end
      if (serve)
        phase3 <= 1'b0;
      else if (state == ST_DRIVE && driving && bus.FAZ3HI)
        phase3 <= 1'b1;
    end
  end

  assign bus.PULSE_P = pulse_p;
  assign bus.PULSE_M = pulse_m;
  assign bus.CHSEL   = chsel;
  assign bus.BUSY    = busy;
  assign bus.PEND    = pend;
  assign bus.OVF     = ovf;

endmodule

// File: tb/tb_cdu_incr_scheduler.sv
// Directed bench for the CDU increment scheduler.
// Frames are 8 cycles: FAZ1@0 FAZ2@2 FAZ3@4 FAZ4@6.
module tb_cdu_incr_scheduler;
  import cdu_pkg::*;

  localparam int NO = 99;

  logic clk;
  logic rst_n;
  int   vec;
  int   miss;

  logic [7:0]     pm;
  logic [7:0]     bm;
  logic           ism;
  logic [2:0]     ch;
  logic           bo;
  logic [NCH-1:0] one;

  cdu_incr_scheduler_if bus();

  cdu_incr_scheduler dut (
    ._51KPHI (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input logic [3:0] f);
    {bus.FAZ1HI, bus.FAZ2HI, bus.FAZ3HI, bus.FAZ4HI} = f;
  endtask

  task automatic inc(input logic [NCH-1:0] p, input logic [NCH-1:0] m);
    bus.INC_P = p;
    bus.INC_M = m;
    tick;
    bus.INC_P = '0;
    bus.INC_M = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #1;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic frame(
    input  logic en, input int en_off, input int x1_c,
    input  int inc_c,
    input  logic [NCH-1:0] ip, input logic [NCH-1:0] im,
    output logic [7:0] pmask, output logic [7:0] bmask,
    output logic is_m, output logic [2:0] chs,
    output logic both
  );
    pmask = '0;
    bmask = '0;
    is_m  = 1'b0;
    chs   = '0;
    both  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.FAZ1HI = (c == 0) || (c == x1_c);
      bus.FAZ2HI = (c == 2);
      bus.FAZ3HI = (c == 4);
      bus.FAZ4HI = (c == 6);
      bus.ENABLE = en && (c < en_off);
      bus.INC_P  = (c == inc_c) ? ip : '0;
      bus.INC_M  = (c == inc_c) ? im : '0;
      tick;
      pmask[c] = bus.PULSE_P | bus.PULSE_M;
      bmask[c] = bus.BUSY;
      if (bus.PULSE_P && bus.PULSE_M) both = 1'b1;
      if (bus.PULSE_M) is_m = 1'b1;
      if (pmask[c]) chs = bus.CHSEL;
    end
    strobes(4'b0000);
    bus.INC_P  = '0;
    bus.INC_M  = '0;
    bus.ENABLE = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.INC_P = '1;
    for (int i = 0; i < 4; i++) begin
      strobes(4'b1000 >> i);
      tick;
    end
    vec++; if (bus.PULSE_P !== 1'b0 || bus.PULSE_M !== 1'b0) begin
      miss++; $display("FAIL rst_pulse got=%b%b want=00", bus.PULSE_P, bus.PULSE_M); end
    vec++; if (bus.CHSEL !== 3'd0 || bus.BUSY !== 1'b0) begin
      miss++; $display("FAIL rst_chsel_busy got=%0d/%b want=0/0", bus.CHSEL, bus.BUSY); end
    vec++; if (bus.PEND !== 5'b0 || bus.OVF !== 5'b0) begin
      miss++; $display("FAIL rst_pend_ovf got=%b/%b want=0/0", bus.PEND, bus.OVF); end
    bus.INC_P = '0;
    strobes(4'b0000);
    rst_n = 1'b1;
    one = '0; one[CH_X] = 1'b1;
    inc(one, '0);
    vec++; if (bus.PEND !== 5'b00001) begin
      miss++; $display("FAIL rst_pend0 got=%b want=00001", bus.PEND); end
    pm = '0;
    bm = '0;
    for (int i = 1; i < 4; i++) begin
      strobes(4'b1000 >> i);
      tick;
      pm[i] = bus.PULSE_P | bus.PULSE_M;
      bm[i] = bus.BUSY;
      strobes(4'b0000);
      tick;
    end
    vec++; if (pm !== 8'h00 || bm !== 8'h00) begin
      miss++; $display("FAIL rst_midframe got=%h/%h want=00/00", pm, bm); end
    frame(1'b1, NO, NO, NO, '0, '0, pm, bm, ism, ch, bo);
    vec++; if (pm !== 8'h3C || ism !== 1'b0 || ch !== 3'd0) begin
      miss++; $display("FAIL rst_first got=%h/%b/%0d want=3c/0/0", pm, ism, ch); end
    vec++; if (bus.PEND !== 5'b0) begin
      miss++; $display("FAIL rst_drained got=%b want=0", bus.PEND); end
  endtask

  task automatic test_single;
    one = '0; one[CH_Y] = 1'b1;
    for (int i = 0; i < 3; i++) inc(one, '0);
    for (int f = 0; f < 3; f++) begin
      frame(1'b1, NO, NO, NO, '0, '0, pm, bm, ism, ch, bo);
      vec++; if (pm !== 8'h3C || ism !== 1'b0 || ch !== 3'd1) begin
        miss++; $display("FAIL single_pulse%0d got=%h/%b/%0d want=3c/0/1", f, pm, ism, ch); end
      vec++; if (bm !== 8'h7F) begin
        miss++; $display("FAIL single_busy%0d got=%h want=7f", f, bm); end
      vec++; if (bus.PEND[CH_Y] !== (f < 2)) begin
        miss++; $display("FAIL single_pend%0d got=%b want=%b", f, bus.PEND[CH_Y], f < 2); end
    end
    vec++; if (bus.CHSEL !== 3'd1) begin
      miss++; $display("FAIL single_hold got=%0d want=1", bus.CHSEL); end
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_ch [4];
    logic       exp_m  [4];
    exp_ch[0] = 3'(CH_X); exp_m[0] = 1'b0;
    exp_ch[1] = 3'(CH_T); exp_m[1] = 1'b1;
    exp_ch[2] = 3'(CH_X); exp_m[2] = 1'b0;
    exp_ch[3] = 3'(CH_T); exp_m[3] = 1'b1;
    do_reset;
    inc(5'b00001, 5'b01000);
    inc(5'b00001, 5'b01000);
    for (int f = 0; f < 4; f++) begin
      frame(1'b1, NO, NO, NO, '0, '0, pm, bm, ism, ch, bo);
      vec++; if (pm !== 8'h3C || ism !== exp_m[f] || ch !== exp_ch[f] || bo !== 1'b0) begin
        miss++; $display("FAIL rr_frame%0d got=%h/%b/%0d/%b want=3c/%b/%0d/0",
          f, pm, ism, ch, bo, exp_m[f], exp_ch[f]); end
    end
    frame(1'b1, NO, NO, NO, '0, '0, pm, bm, ism, ch, bo);
    vec++; if (pm !== 8'h00 || bm !== 8'h00) begin
      miss++; $display("FAIL rr_idle got=%h/%h want=00/00", pm, bm); end
  endtask

  task automatic test_saturation;
    one = '0; one[CH_Z] = 1'b1;
    for (int i = 0; i < 7; i++) inc(one, '0);
    vec++; if (bus.OVF !== 5'b0) begin
      miss++; $display("FAIL sat_at_max got=%b want=0", bus.OVF); end
    inc(one, '0);
    inc(one, '0);
    vec++; if (bus.OVF !== 5'b00100) begin
      miss++; $display("FAIL sat_ovf got=%b want=00100", bus.OVF); end
    for (int f = 0; f < 7; f++) begin
      frame(1'b1, NO, NO, NO, '0, '0, pm, bm, ism, ch, bo);
      vec++; if (pm !== 8'h3C || ism !== 1'b0 || ch !== 3'd2) begin
        miss++; $display("FAIL sat_drain%0d got=%h/%b/%0d want=3c/0/2", f, pm, ism, ch); end
    end
    vec++; if (bus.PEND !== 5'b0 || bus.OVF !== 5'b00100) begin
      miss++; $display("FAIL sat_empty got=%b/%b want=0/00100", bus.PEND, bus.OVF); end
    bus.OVFCLR = 1'b1;
    tick;
    bus.OVFCLR = 1'b0;
    vec++; if (bus.OVF !== 5'b0) begin
      miss++; $display("FAIL sat_clr got=%b want=0", bus.OVF); end
    for (int i = 0; i < 8; i++) inc('0, one);
    vec++; if (bus.OVF !== 5'b0 || bus.PEND !== 5'b00100) begin
      miss++; $display("FAIL sat_at_min got=%b/%b want=0/00100", bus.OVF, bus.PEND); end
    bus.OVFCLR = 1'b1;
    inc('0, one);
    bus.OVFCLR = 1'b0;
    vec++; if (bus.OVF !== 5'b00100) begin
      miss++; $display("FAIL sat_ovf_wins got=%b want=00100", bus.OVF); end
  endtask

  task automatic test_simultaneous;
    do_reset;
    inc(5'b10000, 5'b10000);
    vec++; if (bus.PEND !== 5'b0) begin
      miss++; $display("FAIL sim_cancel0 got=%b want=0", bus.PEND); end
    inc(5'b10000, '0);
    inc(5'b10000, 5'b10000);
    frame(1'b1, NO, NO, NO, '0, '0, pm, bm, ism, ch, bo);
    vec++; if (pm !== 8'h3C || ism !== 1'b0 || ch !== 3'd4) begin
      miss++; $display("FAIL sim_cancel1 got=%h/%b/%0d want=3c/0/4", pm, ism, ch); end
    vec++; if (bus.PEND !== 5'b0) begin
      miss++; $display("FAIL sim_cancel_pend got=%b want=0", bus.PEND); end
    inc(5'b00010, '0);
    frame(1'b1, NO, NO, 6, '0, 5'b00010, pm, bm, ism, ch, bo);
    vec++; if (pm !== 8'h3C || ism !== 1'b0 || ch !== 3'd1) begin
      miss++; $display("FAIL sim_serve_p got=%h/%b/%0d want=3c/0/1", pm, ism, ch); end
    vec++; if (bus.PEND !== 5'b00010) begin
      miss++; $display("FAIL sim_neg_pend got=%b want=00010", bus.PEND); end
    frame(1'b1, NO, NO, NO, '0, '0, pm, bm, ism, ch, bo);
    vec++; if (pm !== 8'h3C || ism !== 1'b1 || ch !== 3'd1 || bo !== 1'b0) begin
      miss++; $display("FAIL sim_serve_m got=%h/%b/%0d/%b want=3c/1/1/0", pm, ism, ch, bo); end
    vec++; if (bus.PEND !== 5'b0) begin
      miss++; $display("FAIL sim_done got=%b want=0", bus.PEND); end
  endtask

  task automatic test_enable;
    inc(5'b00001, '0);
    frame(1'b0, NO, NO, NO, '0, '0, pm, bm, ism, ch, bo);
    vec++; if (pm !== 8'h00 || bm !== 8'h00 || bus.PEND !== 5'b00001) begin
      miss++; $display("FAIL en_off got=%h/%h/%b want=00/00/00001", pm, bm, bus.PEND); end
    frame(1'b1, 1, 3, NO, '0, '0, pm, bm, ism, ch, bo);
    vec++; if (pm !== 8'h3C || bm !== 8'h7F || ch !== 3'd0) begin
      miss++; $display("FAIL en_midframe got=%h/%h/%0d want=3c/7f/0", pm, bm, ch); end
  endtask

  task automatic test_reset_drive;
    do_reset;
    one = '0; one[CH_T] = 1'b1;
    for (int i = 0; i < 8; i++) inc(one, '0);
    inc(5'b00001, '0);
    vec++; if (bus.OVF !== 5'b01000) begin
      miss++; $display("FAIL rd_ovf got=%b want=01000", bus.OVF); end
    for (int c = 0; c < 3; c++) begin
      strobes(c == 0 ? 4'b1000 : (c == 2 ? 4'b0100 : 4'b0000));
      tick;
    end
    strobes(4'b0000);
    vec++; if (bus.PULSE_P !== 1'b1) begin
      miss++; $display("FAIL rd_pulse_on got=%b want=1", bus.PULSE_P); end
    rst_n = 1'b0;
    #1;
    vec++; if (bus.PULSE_P !== 1'b0 || bus.BUSY !== 1'b0) begin
      miss++; $display("FAIL rd_async got=%b/%b want=0/0", bus.PULSE_P, bus.BUSY); end
    tick;
    rst_n = 1'b1;
    tick;
    vec++; if (bus.PEND !== 5'b0 || bus.OVF !== 5'b0) begin
      miss++; $display("FAIL rd_clear got=%b/%b want=0/0", bus.PEND, bus.OVF); end
    frame(1'b1, NO, NO, NO, '0, '0, pm, bm, ism, ch, bo);
    vec++; if (pm !== 8'h00) begin
      miss++; $display("FAIL rd_quiet got=%h want=00", pm); end
  endtask

  initial begin
    vec = 0;
    miss = 0;
    rst_n = 1'b0;
    strobes(4'b0000);
    bus.ENABLE = 1'b1;
    bus.INC_P  = '0;
    bus.INC_M  = '0;
    bus.OVFCLR = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_saturation;
    test_simultaneous;
    test_enable;
    test_reset_drive;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/cdu_incr_scheduler.md
Name: cdu_incr_scheduler

Overview:
Shares the single CDU-to-AGC counter-increment line among the five angle channels (X, Y, Z, T, S). Each channel's read counter emits plus/minus increment pulses; the block accumulates them per channel and drains them one pulse per phase frame. Frames are timed by the FAZ1HI..FAZ4HI strobes from the digital-mode timing generator, and channels are served round-robin. The block sits between the per-channel read counters and the AGC interface drivers.

Parameters:
NCH, 5, number of angle channels sharing the line.
CW, 4, width of each channel's signed pending-count accumulator (two's complement).

Ports:
_51KPHI  in  1  system clock (51.2 kHz phase clock).
rst_n  in  1  reset; asynchronous, active-low.
FAZ1HI  in  1  phase-1 strobe; one-cycle pulse per frame.
FAZ2HI  in  1  phase-2 strobe; one-cycle pulse per frame.
FAZ3HI  in  1  phase-3 strobe; one-cycle pulse per frame.
FAZ4HI  in  1  phase-4 strobe; one-cycle pulse per frame.
ENABLE  in  1  permits new frames to start.
INC_P  in  NCH  per-channel plus-increment pulse, one cycle each.
INC_M  in  NCH  per-channel minus-increment pulse, one cycle each.
OVFCLR  in  1  clears all sticky overflow flags.
PULSE_P  out  1  plus pulse to the AGC line.
PULSE_M  out  1  minus pulse to the AGC line.
CHSEL  out  3  index of the channel being served.
BUSY  out  1  a frame is in progress.
PEND  out  NCH  per-channel "count nonzero" flags.
OVF  out  NCH  per-channel sticky saturation flags.

Behaviour:
- Reset (async, rst_n low): all accumulators 0, FSM IDLE, PULSE_P=PULSE_M=0, CHSEL=0, BUSY=0, PEND=0, OVF=0, round-robin pointer=NCH-1 (so channel 0 is served first). PULSE outputs drop immediately, with no clock edge needed.
- Accumulator update each clock: next = cnt + INC_P[i] - INC_M[i] - served_step[i].
  - served_step is +1 or -1 toward zero, applied only in the FAZ4HI cycle of the frame serving channel i.
  - Simultaneous INC_P and INC_M on one channel cancel.
  - Saturate at +(2^(CW-1)-1) and -2^(CW-1). Any input that would exceed a bound is dropped and sets OVF[i].
  - OVF is sticky until OVFCLR. If OVFCLR and a new overflow occur in the same cycle, the overflow wins (OVF stays 1).
- PEND[i] = (cnt[i] != 0), registered. An INC pulse at cycle t is visible at t+1.
- FSM states: IDLE, ARB, DRIVE, RECOV.
  - IDLE -> ARB: on FAZ1HI when ENABLE=1 and PEND != 0. Otherwise stay in IDLE.
  - ARB (one cycle): select the first channel with PEND set, searching from pointer+1 modulo NCH. Latch CHSEL and sign (positive -> P, negative -> M). Update pointer. Go to DRIVE.
  - DRIVE: on FAZ2HI, assert PULSE_P or PULSE_M (registered, so high from the cycle after the FAZ2HI strobe). Hold through FAZ3HI. On FAZ4HI, deassert the pulse, apply served_step, go to RECOV.
  - RECOV (one cycle): go to IDLE. The next frame starts at the next FAZ1HI at the earliest.
- BUSY = 1 in ARB, DRIVE, RECOV.
- PULSE_P and PULSE_M are never both high.
- CHSEL holds the last served value while IDLE.
- ENABLE deasserted mid-frame: the current frame completes; no new frame starts. Accumulators keep counting.
- Strobes arriving out of order while not in the expected state are ignored; FAZ1HI in DRIVE does not restart arbitration.
- Sign is latched in ARB. If inputs drive the channel's count to zero or flip its sign during the frame, the pulse still completes and served_step follows the latched sign. Saturation is still applied.
- Throughput: at most one pulse per frame.

Decomposition:
- Shared package cdu_pkg:
  - FSM state enum.
  - NCH, CW.
  - Channel index constants CH_X=0, CH_Y=1, CH_Z=2, CH_T=3, CH_S=4.
- One sub-module, cdu_chan_accum: a saturating signed up/down counter with a served-step input and OVF/PEND outputs. Instantiated NCH times.
- Arbiter and FSM live in the top module.

Test Plan:
- Reset: hold rst_n low with INC pulses active -> PULSE_P/M=0, CHSEL=0, BUSY=0, PEND=0, OVF=0. Release mid-frame -> first pulse no earlier than the next FAZ1HI.
- Single channel: three INC_P[1] pulses, ENABLE=1 -> three consecutive frames with PULSE_P high from FAZ2HI+1 through the FAZ4HI cycle and CHSEL=1. PEND[1]=0 after the third FAZ4HI.
- Round-robin: ch0=+2, ch3=-2 -> serve order 0(P), 3(M), 0(P), 3(M), then IDLE.
- Saturation: nine INC_P[2] pulses (CW=4) -> count 7, OVF[2]=1. Seven frames drain it. OVFCLR pulse -> OVF[2]=0.
- Simultaneous events: INC_P[4] and INC_M[4] in the same cycle -> count unchanged. Channel at +1 with INC_M arriving in its FAZ4HI serve cycle -> count -1, next frame gives PULSE_M.
- Reset mid-DRIVE: rst_n low while PULSE_P=1 -> PULSE_P=0 within the same cycle; all counts 0 and OVF 0 after release.
